battle_dp_param: RTL and testbench

BATTLE_DP_PARAM -- requirements
Module: battle_dp_param

---
 rtl/battle_dp_param.sv | 183 ++++++++++++++++++
 tb/tb_battle_dp_param.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/battle_dp_param.sv
// Turn-based battle datapath: a small programmable move table, a free-running
// Galois LFSR for AI move choice and accuracy rolls, and a fixed five-state
// turn sequencer that applies saturating damage to the defender's HP.

// One move-table slot: damage and accuracy, reloaded to its own defaults on reset.
module battle_dp_entry #(
    parameter int               HP_W     = 4,
    parameter int               ACC_W    = 4,
    parameter logic [HP_W-1:0]  RST_DMG  = '0,
    parameter logic [ACC_W-1:0] RST_ACCU = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [HP_W-1:0]  wdmg,
    input  logic [ACC_W-1:0] waccu,
    output logic [HP_W-1:0]  dmg,
    output logic [ACC_W-1:0] accu
);

    // Slot storage; writes are already qualified by the sequencer being idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dmg  <= RST_DMG;
            accu <= RST_ACCU;
        end else if (we) begin
            dmg  <= wdmg;
            accu <= waccu;
        end
    end

endmodule

module battle_dp_param #(
    parameter int          HP_W   = 4,
    parameter int          MOVE_W = 2,
    parameter int          ACC_W  = 4,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stop,
    input  logic              turn_req,
    input  logic              attacker,
    input  logic [MOVE_W-1:0] p_move,
    input  logic              tbl_we,
    input  logic [MOVE_W-1:0] tbl_addr,
    input  logic [HP_W-1:0]   tbl_dmg,
    input  logic [ACC_W-1:0]  tbl_accu,
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic [HP_W-1:0]   p_hp,
    output logic [HP_W-1:0]   ai_hp,
    output logic [HP_W-1:0]   dmg,
    output logic [ACC_W-1:0]  accu,
    output logic [ACC_W-1:0]  roll,
    output logic              p_dead,
    output logic              ai_dead
);

    localparam int ENTRIES = 1 << MOVE_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ROLL  = 3'd2;
    localparam logic [2:0] S_APPLY = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Default accuracy falls by two per slot and floors at zero.
    function automatic logic [ACC_W-1:0] rst_accu(input int idx);
        int v;
        v = (1 << ACC_W) - 1 - 2 * idx;
        return (v < 0) ? '0 : ACC_W'(v);
    endfunction

    logic [2:0]              state;
    logic [15:0]             lfsr;
    logic                    att_r;
    logic [MOVE_W-1:0]       move_r;
    logic                    accept;
    logic                    hit_now;
    logic [HP_W-1:0]         def_hp;
    logic [HP_W-1:0]         def_hp_next;

    logic [ENTRIES-1:0][HP_W-1:0]  dmg_tbl;
    logic [ENTRIES-1:0][ACC_W-1:0] accu_tbl;

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign p_dead  = (p_hp == '0);
    assign ai_dead = (ai_hp == '0);

    // Requests are only honoured from idle with both fighters alive; nothing queues.
    assign accept = (state == S_IDLE) && turn_req && !p_dead && !ai_dead;

    // Full accuracy is a guaranteed hit even though roll can equal all-ones.
    assign hit_now = (roll < accu) || (accu == '1);

    assign def_hp      = att_r ? p_hp : ai_hp;
    assign def_hp_next = (dmg > def_hp) ? '0 : def_hp - dmg;

    genvar i;
    generate
        for (i = 0; i < ENTRIES; i++) begin : g_tbl
            localparam logic [HP_W-1:0]  RD = HP_W'(i + 1);
            localparam logic [ACC_W-1:0] RA = rst_accu(i);
            battle_dp_entry #(
                .HP_W    (HP_W),
                .ACC_W   (ACC_W),
                .RST_DMG (RD),
                .RST_ACCU(RA)
            ) u_entry (
                .clk  (clk),
                .rst  (rst),
                .we   (tbl_we && !busy && (tbl_addr == MOVE_W'(i))),
                .wdmg (tbl_dmg),
                .waccu(tbl_accu),
                .dmg  (dmg_tbl[i]),
                .accu (accu_tbl[i])
            );
        end
    endgenerate

    // Galois LFSR, x^16+x^14+x^13+x^11, shifting right; stop only freezes it.
    always_ff @(posedge clk) begin
        if (!rst)
            lfsr <= SEED;
        else if (!stop)
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Turn sequencer: capture, fetch, roll, apply, report; reset aborts cleanly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            att_r  <= 1'b0;
            move_r <= '0;
            dmg    <= '0;
            accu   <= '0;
            roll   <= '0;
            hit    <= 1'b0;
            p_hp   <= '1;
            ai_hp  <= '1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        att_r  <= attacker;
                        move_r <= attacker ? lfsr[MOVE_W-1:0] : p_move;
                        state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    dmg   <= dmg_tbl[move_r];
                    accu  <= accu_tbl[move_r];
                    state <= S_ROLL;
                end
                S_ROLL: begin
                    roll  <= lfsr[ACC_W+7:8];
                    state <= S_APPLY;
                end
                S_APPLY: begin
                    hit <= hit_now;
                    if (hit_now) begin
                        if (att_r)
                            p_hp <= def_hp_next;
                        else
                            ai_hp <= def_hp_next;
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_battle_dp_param.sv
// Directed bench for battle_dp_param: a table of player turns with hand-computed
// results, then hand-written sequences for death lockout, AI turns against a
// reference LFSR, stop, and mid-turn reset.
module tb_battle_dp_param;

    logic       clk;
    logic       rst;
    logic       stop;
    logic       turn_req;
    logic       attacker;
    logic [1:0] p_move;
    logic       tbl_we;
    logic [1:0] tbl_addr;
    logic [3:0] tbl_dmg;
    logic [3:0] tbl_accu;
    logic       busy, done, hit, p_dead, ai_dead;
    logic [3:0] p_hp, ai_hp, dmg, accu, roll;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_lfsr;
    logic [15:0] last_l;

    battle_dp_param #(.HP_W(4), .MOVE_W(2), .ACC_W(4), .SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .stop(stop), .turn_req(turn_req), .attacker(attacker),
        .p_move(p_move), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_dmg(tbl_dmg),
        .tbl_accu(tbl_accu), .busy(busy), .done(done), .hit(hit), .p_hp(p_hp),
        .ai_hp(ai_hp), .dmg(dmg), .accu(accu), .roll(roll), .p_dead(p_dead),
        .ai_dead(ai_dead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: shift right, feed the dropped bit into taps 16,14,13,11.
    function automatic logic [15:0] adv(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) begin
            n[15] = ~n[15];
            n[13] = ~n[13];
            n[12] = ~n[12];
            n[10] = ~n[10];
        end
        return n;
    endfunction

    // Reference LFSR tracks the DUT's reset and stop behaviour.
    always @(posedge clk) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else if (!stop) m_lfsr <= adv(m_lfsr);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic [3:0] ac);
        tbl_we = 1'b1; tbl_addr = a; tbl_dmg = d; tbl_accu = ac;
        step();
        tbl_we = 1'b0;
    endtask

    // Issue one turn; returns edges from acceptance to done (0 = timed out).
    // With poke set, request and table write are attempted while busy, and the
    // request is raised again during the done cycle.
    task automatic turn(input logic att, input logic [1:0] mv, input bit poke, output int lat);
        attacker = att; p_move = mv; turn_req = 1'b1; last_l = m_lfsr;
        step();
        turn_req = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            if (poke && k == 1) begin
                turn_req = 1'b1; tbl_we = 1'b1; tbl_addr = 2'd0; tbl_dmg = 4'd9; tbl_accu = 4'd15;
            end
            step();
            turn_req = 1'b0; tbl_we = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        if (poke) turn_req = 1'b1;
    endtask

    typedef struct {
        logic       att;
        logic [1:0] mv;
        bit         poke;
        int         e_hit;
        int         e_dmg;
        int         e_accu;
        int         e_ai;
        int         e_p;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int lat, nd, maxb, exp_move, exp_p, exp_hit;
        logic [15:0] l2;

        vecs[0] = '{att: 1'b0, mv: 2'd1, poke: 1'b0, e_hit: 1, e_dmg: 3,  e_accu: 15, e_ai: 12, e_p: 15};
        vecs[1] = '{att: 1'b0, mv: 2'd0, poke: 1'b1, e_hit: 0, e_dmg: 1,  e_accu: 0,  e_ai: 12, e_p: 15};
        vecs[2] = '{att: 1'b0, mv: 2'd0, poke: 1'b0, e_hit: 0, e_dmg: 1,  e_accu: 0,  e_ai: 12, e_p: 15};
        vecs[3] = '{att: 1'b0, mv: 2'd2, poke: 1'b0, e_hit: 1, e_dmg: 15, e_accu: 15, e_ai: 0,  e_p: 15};

        rst = 1'b0; stop = 1'b0; turn_req = 1'b0; attacker = 1'b0; p_move = '0;
        tbl_we = 1'b0; tbl_addr = '0; tbl_dmg = '0; tbl_accu = '0;
        step();
        chk("rst_p_hp", p_hp, 15);
        chk("rst_ai_hp", ai_hp, 15);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hit", hit, 0);
        chk("rst_p_dead", p_dead, 0);
        chk("rst_ai_dead", ai_dead, 0);
        chk("rst_dmg", dmg, 0);
        chk("rst_accu", accu, 0);
        chk("rst_roll", roll, 0);
        rst = 1'b1;
        step();

        wr(2'd1, 4'd3, 4'd15);
        wr(2'd0, 4'd1, 4'd0);
        wr(2'd2, 4'd15, 4'd15);

        foreach (vecs[v]) begin
            turn(vecs[v].att, vecs[v].mv, vecs[v].poke, lat);
            chk($sformatf("v%0d_latency", v), lat, 3);
            chk($sformatf("v%0d_busy_in_done", v), busy, 1);
            chk($sformatf("v%0d_hit", v), hit, vecs[v].e_hit);
            chk($sformatf("v%0d_dmg", v), dmg, vecs[v].e_dmg);
            chk($sformatf("v%0d_accu", v), accu, vecs[v].e_accu);
            chk($sformatf("v%0d_ai_hp", v), ai_hp, vecs[v].e_ai);
            chk($sformatf("v%0d_p_hp", v), p_hp, vecs[v].e_p);
            step();
            turn_req = 1'b0;
            chk($sformatf("v%0d_done_clear", v), done, 0);
            chk($sformatf("v%0d_busy_clear", v), busy, 0);
            if (vecs[v].poke) begin
                nd = 0;
                for (int k = 0; k < 6; k++) begin
                    if (done || busy) nd++;
                    step();
                end
                chk($sformatf("v%0d_no_second_turn", v), nd, 0);
            end
        end

        chk("ai_dead_after_kill", ai_dead, 1);
        chk("p_dead_after_kill", p_dead, 0);
        turn_req = 1'b1;
        step();
        turn_req = 1'b0;
        maxb = busy;
        for (int k = 0; k < 4; k++) begin
            step();
            if (busy) maxb = 1;
        end
        chk("dead_ignores_req", maxb, 0);
        chk("dead_ai_hp_held", ai_hp, 0);

        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rst2_ai_hp", ai_hp, 15);
        for (int e = 0; e < 4; e++) wr(2'(e), 4'(e + 2), 4'd15);

        turn(1'b1, 2'd0, 1'b0, lat);
        exp_move = int'(last_l[1:0]);
        exp_p = 15 - (exp_move + 2);
        l2 = adv(adv(last_l));
        chk("ai_latency", lat, 3);
        chk("ai_hit", hit, 1);
        chk("ai_dmg", dmg, exp_move + 2);
        chk("ai_p_hp", p_hp, exp_p);
        chk("ai_ai_hp", ai_hp, 15);
        chk("ai_roll", roll, int'(l2[11:8]));
        step();

        stop = 1'b1;
        step();
        turn(1'b1, 2'd0, 1'b0, lat);
        exp_move = int'(last_l[1:0]);
        exp_p = exp_p - (exp_move + 2);
        chk("stop_latency", lat, 3);
        chk("stop_dmg", dmg, exp_move + 2);
        chk("stop_p_hp", p_hp, exp_p);
        chk("stop_roll", roll, int'(last_l[11:8]));
        step();
        stop = 1'b0;
        step();

        attacker = 1'b0; p_move = 2'd1; turn_req = 1'b1;
        step();
        turn_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("abort_p_hp", p_hp, 15);
        chk("abort_ai_hp", ai_hp, 15);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        nd = 0;
        for (int k = 0; k < 5; k++) begin
            if (done || busy) nd++;
            step();
        end
        chk("abort_no_done", nd, 0);

        turn(1'b0, 2'd1, 1'b0, lat);
        l2 = adv(adv(last_l));
        exp_hit = (l2[11:8] < 4'd13) ? 1 : 0;
        chk("restore_latency", lat, 3);
        chk("restore_dmg", dmg, 2);
        chk("restore_accu", accu, 13);
        chk("restore_roll", roll, int'(l2[11:8]));
        chk("restore_hit", hit, exp_hit);
        chk("restore_ai_hp", ai_hp, exp_hit ? 13 : 15);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
